// File: rtl/pipe_stage_skid.sv
// Pipeline stage latch with valid/ready handshake and a 2-entry skid buffer.
// Carries LANES data words plus FLAG_W sideband flags as one word; empty stage emits a zero bubble.
module pipe_stage_skid #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LANES  = 3,
   parameter int unsigned FLAG_W = 2
) (
   input  logic                      clk,
   input  logic                      clr,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*DATA_W-1:0]   in_data,
   input  logic [FLAG_W-1:0]         in_flags,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*DATA_W-1:0]   out_data,
   output logic [FLAG_W-1:0]         out_flags,
   output logic [1:0]                count
);

   localparam int unsigned PAY_W  = LANES * DATA_W;
   localparam int unsigned WORD_W = PAY_W + FLAG_W;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [WORD_W-1:0]   main_q, main_d;
   logic [WORD_W-1:0]   skid_q, skid_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic [1:0]          count_q, count_d;

   logic                accept;
   logic                pop;
   logic [WORD_W-1:0]   in_word;

   // Handshake terms use only registered ready/valid, keeping out_ready off the in_ready path.
   always_comb begin
      accept  = in_valid & in_ready_q;
      pop     = out_valid_q & out_ready;
      in_word = {in_flags, in_data};
   end

   // Next-state and storage movement; flush overrides every transition.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = S_EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  state_d = S_ONE;
                  main_d  = in_word;
               end
            end
            S_ONE: begin
               case ({accept, pop})
                  2'b10: begin
                     state_d = S_TWO;
                     skid_d  = in_word;
                  end
                  2'b11: begin
                     main_d  = in_word;
                  end
                  2'b01: begin
                     state_d = S_EMPTY;
                     main_d  = '0;
                  end
                  default: begin
                     state_d = S_ONE;
                  end
               endcase
            end
            S_TWO: begin
               if (pop) begin
                  state_d = S_ONE;
                  main_d  = skid_q;
                  skid_d  = '0;
               end
            end
            default: begin
               state_d = S_EMPTY;
               main_d  = '0;
               skid_d  = '0;
            end
         endcase
      end
   end

   // Status outputs are precomputed from the next state so they leave straight from flops.
   always_comb begin
      in_ready_d  = (state_d != S_TWO);
      out_valid_d = (state_d != S_EMPTY);
      case (state_d)
         S_ONE:   count_d = 2'd1;
         S_TWO:   count_d = 2'd2;
         default: count_d = 2'd0;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q     <= S_EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         count_q     <= 2'd0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         count_q     <= count_d;
      end
   end

   // Head word masked by valid so an empty stage always presents a NOP.
   always_comb begin
      in_ready  = in_ready_q;
      out_valid = out_valid_q;
      count     = count_q;
      out_data  = main_q[PAY_W-1:0] & {PAY_W{out_valid_q}};
      out_flags = main_q[WORD_W-1:PAY_W] & {FLAG_W{out_valid_q}};
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: queue scoreboard fed at accept, checked at the head every cycle.
module tb_pipe_stage_skid;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned LANES  = 3;
   localparam int unsigned FLAG_W = 2;
   localparam int unsigned PAY_W  = LANES * DATA_W;
   localparam int unsigned WORD_W = PAY_W + FLAG_W;

   logic                 clk = 1'b0;
   logic                 clr = 1'b0;
   logic                 flush = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [PAY_W-1:0]     in_data = '0;
   logic [FLAG_W-1:0]    in_flags = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [PAY_W-1:0]     out_data;
   logic [FLAG_W-1:0]    out_flags;
   logic [1:0]           count;

   logic [WORD_W-1:0]    sb_q[$];
   int                   n_chk = 0;
   int                   n_bad = 0;
   int                   n_pop = 0;
   logic                 mon_en = 1'b0;

   pipe_stage_skid #(.DATA_W(DATA_W), .LANES(LANES), .FLAG_W(FLAG_W)) dut (
      .clk       (clk),
      .clr       (clr),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_flags  (in_flags),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_flags (out_flags),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [PAY_W-1:0] d, input logic [FLAG_W-1:0] f);
      in_valid = v;
      in_data  = d;
      in_flags = f;
   endtask

   // Model: compare head every cycle, then apply pop/accept/flush as the next edge will.
   always @(negedge clk) begin
      int sz;
      if (mon_en && !clr) begin
         sz = sb_q.size();
         chk("mon_count", 128'(count), 128'(sz));
         chk("mon_out_valid", 128'(out_valid), 128'(sz != 0));
         chk("mon_in_ready", 128'(in_ready), 128'(sz < 2));
         if (sz != 0) chk("mon_head", 128'({out_flags, out_data}), 128'(sb_q[0]));
         else         chk("mon_bubble", 128'({out_flags, out_data}), 128'(0));
         if (out_ready && sz != 0) begin
            void'(sb_q.pop_front());
            n_pop++;
         end
         if (flush) sb_q.delete();
         else if (in_valid && sz < 2) sb_q.push_back({in_flags, in_data});
      end
   end

   // Push {3,2,1} flags 10 with out_ready high; it shows next cycle, then drains to a bubble.
   task automatic single_pass(input string tag);
      out_ready = 1'b1;
      drive(1'b1, {32'h3, 32'h2, 32'h1}, 2'b10);
      step();
      drive(1'b0, '0, '0);
      chk({tag, "_valid"}, 128'(out_valid), 128'(1));
      chk({tag, "_lane0"}, 128'(out_data[0 +: 32]), 128'(32'h1));
      chk({tag, "_lane1"}, 128'(out_data[32 +: 32]), 128'(32'h2));
      chk({tag, "_lane2"}, 128'(out_data[64 +: 32]), 128'(32'h3));
      chk({tag, "_flags"}, 128'(out_flags), 128'(2'b10));
      chk({tag, "_count1"}, 128'(count), 128'(1));
      step();
      chk({tag, "_count0"}, 128'(count), 128'(0));
      chk({tag, "_zero"}, 128'(out_data), 128'(0));
   endtask

   task automatic fill_two(input logic [31:0] base);
      out_ready = 1'b0;
      drive(1'b1, {base + 32'd2, base + 32'd1, base}, 2'b01);
      step();
      drive(1'b1, {base + 32'd12, base + 32'd11, base + 32'd10}, 2'b11);
      step();
      drive(1'b0, '0, '0);
   endtask

   initial begin
      int t;
      int pops0;
      logic was_ready;

      // Reset with garbage inputs, checked before any clock edge.
      drive(1'b1, {PAY_W{1'b1}}, 2'b11);
      out_ready = 1'b1;
      flush = 1'b1;
      #1 clr = 1'b1;
      #1;
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_data", 128'(out_data), 128'(0));
      chk("rst_out_flags", 128'(out_flags), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_count", 128'(count), 128'(0));
      step();
      drive(1'b0, '0, '0);
      flush = 1'b0;
      out_ready = 1'b0;
      clr = 1'b0;
      mon_en = 1'b1;

      single_pass("pass");

      // Backpressure: X1, X2 fill the stage, X3 waits upstream.
      fill_two(32'h100);
      chk("bp_count2", 128'(count), 128'(2));
      chk("bp_in_ready0", 128'(in_ready), 128'(0));
      drive(1'b1, {32'h122, 32'h121, 32'h120}, 2'b10);
      step();
      chk("bp_held_count", 128'(count), 128'(2));
      pops0 = n_pop;
      out_ready = 1'b1;
      t = 0;
      was_ready = 1'b0;
      while (!was_ready && t < 10) begin
         was_ready = in_ready;
         step();
         t++;
      end
      chk("bp_x3_accept_to", 128'(was_ready), 128'(1));
      drive(1'b0, '0, '0);
      t = 0;
      while (sb_q.size() != 0 && t < 20) begin
         step();
         t++;
      end
      chk("bp_drain_to", 128'(t < 20), 128'(1));
      chk("bp_pops", 128'(n_pop - pops0), 128'(3));

      // Full throughput with incrementing payload.
      pops0 = n_pop;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, {32'(i + 32'h2000), 32'(i + 32'h1000), 32'(i)}, 2'(i));
         step();
         chk("tp_count", 128'(count), 128'(1));
      end
      drive(1'b0, '0, '0);
      step();
      chk("tp_pops", 128'(n_pop - pops0), 128'(16));
      chk("tp_empty", 128'(count), 128'(0));

      // Flush while full with a live input.
      fill_two(32'h300);
      flush = 1'b1;
      drive(1'b1, {32'hDEAD, 32'hBEEF, 32'hCAFE}, 2'b11);
      step();
      flush = 1'b0;
      drive(1'b0, '0, '0);
      chk("fl2_count", 128'(count), 128'(0));
      chk("fl2_out_valid", 128'(out_valid), 128'(0));
      chk("fl2_out_data", 128'(out_data), 128'(0));
      repeat (3) step();

      // Flush at ONE with an accepted input and a pop in the same cycle.
      out_ready = 1'b0;
      drive(1'b1, {32'h402, 32'h401, 32'h400}, 2'b01);
      step();
      out_ready = 1'b1;
      flush = 1'b1;
      drive(1'b1, {32'h5A5A, 32'h5A5A, 32'h5A5A}, 2'b10);
      step();
      flush = 1'b0;
      drive(1'b0, '0, '0);
      chk("fl1_count", 128'(count), 128'(0));
      chk("fl1_out_data", 128'(out_data), 128'(0));
      repeat (2) step();

      // Async clr mid-cycle while full, then a normal pass.
      fill_two(32'h600);
      #2 clr = 1'b1;
      #1;
      chk("aclr_out_valid", 128'(out_valid), 128'(0));
      chk("aclr_out_data", 128'(out_data), 128'(0));
      chk("aclr_count", 128'(count), 128'(0));
      chk("aclr_in_ready", 128'(in_ready), 128'(1));
      sb_q.delete();
      #1 clr = 1'b0;
      step();
      single_pass("post_clr");
      repeat (2) step();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
